// File: rtl/module_receiver.sv
// module_receiver
//   Downstream stage of module_sender. Accepts DATA_WIDTH-bit words over a
//   4-phase Req/Ack handshake and writes each one to a local memory port.
//   After WORDS words it stops accepting and raises Ready. A Receive pulse
//   while Ready is high re-arms the block for the next transfer.
//
//   Optional build macro: REQ_SYNC_EN
//     When defined, Req passes through a 2-flop synchronizer before the FSM.
//     This adds two cycles of handshake latency in each direction.
//     Use it when the sender runs on an unrelated clock.
//
// Ports
//   Clock        in   1           system clock, rising edge
//   Reset        in   1           synchronous, active-high
//   Req          in   1           sender request, DataIn valid while high
//   DataIn       in   DATA_WIDTH  word from sender
//   Receive      in   1           re-arm pulse, honoured only in DONE
//   Ack          out  1           handshake acknowledge to sender
//   DataOut      out  DATA_WIDTH  captured word to memory
//   Address      out  ADDR_WIDTH  memory write address
//   WriteEnable  out  1           one-cycle memory write strobe
//   Ready        out  1           block complete, high in DONE
module module_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int WORDS      = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Receive,
  output logic                  Ack,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WriteEnable,
  output logic                  Ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Address of the final word of a block. WORDS = 2**ADDR_WIDTH yields the
  // all-ones address, so the counter never has to wrap inside a block.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

  function automatic logic is_last(input logic [ADDR_WIDTH-1:0] addr);
    return addr == LAST_ADDR;
  endfunction

  logic [1:0] state;
  logic       req_s;

`ifdef REQ_SYNC_EN
  logic req_p0;
  logic req_p1;

  // Synchronizer stage 0 -> 1; both flops clear on reset so that a stale
  // request cannot be replayed after a reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      req_p0 <= 1'b0;
      req_p1 <= 1'b0;
    end else begin
      req_p0 <= Req;
      req_p1 <= req_p0;
    end
  end

  assign req_s = req_p1;
`else
  assign req_s = Req;
`endif

  // Handshake FSM stage
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      Ack         <= 1'b0;
      DataOut     <= '0;
      Address     <= '0;
      WriteEnable <= 1'b0;
      Ready       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_s) begin
            DataOut     <= DataIn;
            WriteEnable <= 1'b1;
            Ack         <= 1'b1;
            state       <= ST_ACK;
          end
        end
        ST_ACK: begin
          // The write strobe is only ever one cycle wide.
          WriteEnable <= 1'b0;
          if (!req_s) begin
            Ack <= 1'b0;
            if (is_last(Address)) begin
              Ready <= 1'b1;
              state <= ST_DONE;
            end else begin
              Address <= Address + 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          // Req is deliberately ignored here; only Receive leaves DONE.
          if (Receive) begin
            Address <= '0;
            Ready   <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_receiver.sv
module tb_module_receiver;

`ifdef REQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        Clock;
  logic        Reset;
  logic        Req;
  logic [15:0] DataIn;
  logic        Receive;
  logic        Ack;
  logic [15:0] DataOut;
  logic [3:0]  Address;
  logic        WriteEnable;
  logic        Ready;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [16];

  module_receiver #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4),
    .WORDS(16)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Req(Req),
    .DataIn(DataIn),
    .Receive(Receive),
    .Ack(Ack),
    .DataOut(DataOut),
    .Address(Address),
    .WriteEnable(WriteEnable),
    .Ready(Ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory attached to the write port
  always @(posedge Clock) begin
    if (WriteEnable) mem[Address] <= DataOut;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One full 4-phase handshake carrying word d.
  task automatic do_word(input logic [15:0] d);
    int n;
    DataIn = d;
    Req    = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!Ack && n < 20);
    chk("ack_rise", 32'(Ack), 32'd1);
    chk("we_on_ack", 32'(WriteEnable), 32'd1);
    chk("dataout", 32'(DataOut), 32'(d));
    tick();
    chk("we_one_cycle", 32'(WriteEnable), 32'd0);
    Req = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (Ack && n < 20);
    chk("ack_fall", 32'(Ack), 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset   = 1'b0;
    Req     = 1'b0;
    DataIn  = 16'h0000;
    Receive = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'hxxxx;

    // 1. reset state
    do_reset();
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_we", 32'(WriteEnable), 32'd0);
    chk("rst_ready", 32'(Ready), 32'd0);
    chk("rst_addr", 32'(Address), 32'd0);
    chk("rst_dout", 32'(DataOut), 32'd0);

    // 2. single word with exact latency
    DataIn = 16'h00A5;
    Req    = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      chk("ack_early", 32'(Ack), 32'd0);
    end
    tick();
    chk("t2_ack", 32'(Ack), 32'd1);
    chk("t2_we", 32'(WriteEnable), 32'd1);
    chk("t2_dout", 32'(DataOut), 32'h00A5);
    chk("t2_addr", 32'(Address), 32'd0);
    tick();
    chk("t2_we_off", 32'(WriteEnable), 32'd0);
    chk("t2_ack_hold", 32'(Ack), 32'd1);
    Req = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      chk("ack_hold_fall", 32'(Ack), 32'd1);
    end
    tick();
    chk("t2_ack_fall", 32'(Ack), 32'd0);
    chk("t2_addr_inc", 32'(Address), 32'd1);
    chk("t2_ready", 32'(Ready), 32'd0);

    // 3. full block of 16 words
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_word(16'(i + 1));
      chk("blk_ready", 32'(Ready), (i == 15) ? 32'd1 : 32'd0);
    end
    chk("blk_last_addr", 32'(Address), 32'd15);
    for (int i = 0; i < 16; i++) chk("blk_mem", 32'(mem[i]), 32'(i + 1));
    // 17th request must be ignored in DONE
    DataIn = 16'hDEAD;
    Req    = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      chk("done_no_ack", 32'(Ack), 32'd0);
      chk("done_no_we", 32'(WriteEnable), 32'd0);
    end
    chk("done_ready", 32'(Ready), 32'd1);
    chk("done_addr", 32'(Address), 32'd15);
    Req = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick();
    chk("done_mem15", 32'(mem[15]), 32'd16);

    // 4. re-arm with Receive
    Receive = 1'b1;
    tick();
    Receive = 1'b0;
    chk("rearm_ready", 32'(Ready), 32'd0);
    chk("rearm_addr", 32'(Address), 32'd0);
    do_word(16'hBEEF);
    chk("rearm_mem0", 32'(mem[0]), 32'hBEEF);
    chk("rearm_addr1", 32'(Address), 32'd1);
    // Receive outside DONE is ignored
    Receive = 1'b1;
    tick();
    Receive = 1'b0;
    chk("recv_ignored", 32'(Address), 32'd1);

    // 5. reset mid-handshake
    do_reset();
    do_word(16'h1111);
    do_word(16'h2222);
    do_word(16'h3333);
    chk("mid_addr3", 32'(Address), 32'd3);
    DataIn = 16'h4444;
    Req    = 1'b1;
    for (int i = 0; i < LAT; i++) tick();
    chk("mid_ack_hi", 32'(Ack), 32'd1);
    Reset = 1'b1;
    Req   = 1'b0;
    tick();
    chk("mid_rst_ack", 32'(Ack), 32'd0);
    chk("mid_rst_addr", 32'(Address), 32'd0);
    chk("mid_rst_we", 32'(WriteEnable), 32'd0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_idle_ack", 32'(Ack), 32'd0);
    do_word(16'h5555);
    chk("fresh_mem0", 32'(mem[0]), 32'h5555);
    chk("fresh_addr", 32'(Address), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
